// File: rtl/dec_rat_recover_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dec_rat_recover_ctrl_pkg
// Shared rename-stage constants and the flush-recovery FSM encoding.
//   ARF_NUM / ARF_W : architectural register count and code width
//   PRF_W           : physical register code width
//   LANES           : speculative RAT write ports used per walk beat
//   BEATS / IDX_W   : walk length in beats and beat-index width
// ---------------------------------------------------------------------------
package dec_rat_recover_ctrl_pkg;

  localparam int ARF_NUM = 32;
  localparam int ARF_W   = 5;
  localparam int PRF_W   = 6;
  localparam int LANES   = 4;

  localparam int LANE_W  = $clog2(LANES);
  localparam int BEATS   = ARF_NUM / LANES;
  localparam int IDX_W   = $clog2(BEATS);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } recover_state_t;

endpackage

// File: rtl/dec_rat_recover_ctrl_if.sv
// ---------------------------------------------------------------------------
// dec_rat_recover_ctrl_if
// Speculative RAT write-port bundle used by the recovery walk.
//   o_srat_wren         : per-lane write enable        (master -> slave)
//   o_srat_wr_arf_code  : per-lane architectural code  (master -> slave)
//   o_srat_wr_prf_code  : per-lane physical code       (master -> slave)
//   i_srat_wr_ready     : RAT accepts the current beat (slave -> master)
// The i_/o_ prefixes are named from the recovery controller's side.
// ---------------------------------------------------------------------------
interface dec_rat_recover_ctrl_if;
  import dec_rat_recover_ctrl_pkg::*;

  logic [LANES-1:0]       o_srat_wren;
  logic [LANES*ARF_W-1:0] o_srat_wr_arf_code;
  logic [LANES*PRF_W-1:0] o_srat_wr_prf_code;
  logic                   i_srat_wr_ready;

  modport master (
    output o_srat_wren,
    output o_srat_wr_arf_code,
    output o_srat_wr_prf_code,
    input  i_srat_wr_ready
  );

  modport slave (
    input  o_srat_wren,
    input  o_srat_wr_arf_code,
    input  o_srat_wr_prf_code,
    output i_srat_wr_ready
  );

endinterface

// File: rtl/dec_rat_recover_lane_mux.sv
// ---------------------------------------------------------------------------
// dec_rat_recover_lane_mux
// Picks the LANES ARAT entries addressed by one walk beat out of the flat
// ARAT read bus and builds the per-lane write port values.
//   i_walk                 : walk beat is being presented (gates all lanes)
//   i_ready                : RAT accepts the beat this cycle
//   i_idx                  : beat index
//   i_arat_flush_prf_code  : all ARAT entries, entry k at [k*PRF_W +: PRF_W]
//   o_wren / o_arf / o_prf : per-lane write enable, arch code, phys code
// ---------------------------------------------------------------------------
module dec_rat_recover_lane_mux
  import dec_rat_recover_ctrl_pkg::*;
(
  input  logic                     i_walk,
  input  logic                     i_ready,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic [ARF_NUM*PRF_W-1:0] i_arat_flush_prf_code,
  output logic [LANES-1:0]         o_wren,
  output logic [LANES*ARF_W-1:0]   o_arf,
  output logic [LANES*PRF_W-1:0]   o_prf
);

  logic [PRF_W-1:0] w_arat_entry [ARF_NUM];

  genvar gi;

  generate
    for (gi = 0; gi < ARF_NUM; gi++) begin : g_entry
      assign w_arat_entry[gi] = i_arat_flush_prf_code[gi*PRF_W +: PRF_W];
    end

    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LANE_W-1:0] LANE_ID = LANE_W'(gi);
      logic [ARF_W-1:0] w_arf;

      // Beats are LANES-aligned, so the lane number is just the low bits.
      assign w_arf = {i_idx, LANE_ID};

      // x0 is hard-wired zero in the RAT and must never be rewritten.
      assign o_wren[gi]                 = i_walk & i_ready & (w_arf != '0);
      assign o_arf[gi*ARF_W +: ARF_W]   = i_walk ? w_arf : '0;
      assign o_prf[gi*PRF_W +: PRF_W]   = i_walk ? w_arat_entry[w_arf] : '0;
    end
  endgenerate

endmodule

// File: rtl/dec_rat_recover_ctrl.sv
// ---------------------------------------------------------------------------
// dec_rat_recover_ctrl
// Flush-recovery sequencer: on a ROB flush, copies the committed ARAT into
// the speculative RAT LANES entries per beat, holding rename and retire
// stalled for the whole walk, then pulses o_recover_done for one cycle.
//   clk, rst_n             : core clock, asynchronous active-low reset
//   i_flush_req            : single-cycle flush pulse from the ROB
//   i_arat_flush_prf_code  : all ARAT entries, entry k at [k*PRF_W +: PRF_W]
//   srat                   : speculative RAT write ports (master side)
//   o_rename_stall         : blocks rename/dispatch
//   o_retire_stall         : blocks ARAT retire writes
//   o_recover_done         : one-cycle completion pulse
// ---------------------------------------------------------------------------
module dec_rat_recover_ctrl
  import dec_rat_recover_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush_req,
  input  logic [ARF_NUM*PRF_W-1:0] i_arat_flush_prf_code,
  dec_rat_recover_ctrl_if.master   srat,
  output logic                     o_rename_stall,
  output logic                     o_retire_stall,
  output logic                     o_recover_done
);

  recover_state_t r_state;
  logic [IDX_W-1:0] r_idx;

  logic                   w_walk;
  logic                   w_ready;
  logic                   w_stall;
  logic [LANES-1:0]       w_wren;
  logic [LANES*ARF_W-1:0] w_arf;
  logic [LANES*PRF_W-1:0] w_prf;

  assign w_walk  = (r_state == WALK);
  assign w_ready = srat.i_srat_wr_ready;

  dec_rat_recover_lane_mux u_lane_mux (
    .i_walk                (w_walk),
    .i_ready               (w_ready),
    .i_idx                 (r_idx),
    .i_arat_flush_prf_code (i_arat_flush_prf_code),
    .o_wren                (w_wren),
    .o_arf                 (w_arf),
    .o_prf                 (w_prf)
  );

  assign srat.o_srat_wren        = w_wren;
  assign srat.o_srat_wr_arf_code = w_arf;
  assign srat.o_srat_wr_prf_code = w_prf;

  // The flush term lets the stall cover the flush cycle itself, before the
  // state register has moved out of IDLE.
  assign w_stall        = (r_state != IDLE) | i_flush_req;
  assign o_rename_stall = w_stall;
  assign o_retire_stall = w_stall;

  // A flush landing on the DONE cycle restarts the walk, so the pulse would
  // be a false completion.
  assign o_recover_done = (r_state == DONE) & ~i_flush_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_flush_req) begin
            r_state <= WALK;
            r_idx   <= '0;
          end
        end

        WALK: begin
          if (i_flush_req) begin
            // Any beat written this cycle is simply rewritten by the restart.
            r_idx <= '0;
          end else if (w_ready) begin
            // Incrementing past the last beat wraps the index back to zero.
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == IDX_LAST) begin
              r_state <= DONE;
            end
          end
        end

        DONE: begin
          if (i_flush_req) begin
            r_state <= WALK;
            r_idx   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_rat_recover_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dec_rat_recover_ctrl
// Directed bench for the flush-recovery sequencer. Each step drives the
// inputs just after a rising edge and checks every output at the falling
// edge against values derived from a reference ARAT table and the expected
// beat number for that cycle.
// ---------------------------------------------------------------------------
module tb_dec_rat_recover_ctrl;
  import dec_rat_recover_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  logic ready;
  logic [ARF_NUM*PRF_W-1:0] arat_bus;
  logic rename_stall;
  logic retire_stall;
  logic recover_done;

  logic [PRF_W-1:0] arat_m [ARF_NUM];

  int n_chk;
  int n_err;
  int wr_cnt;

  dec_rat_recover_ctrl_if srat_if ();

  assign srat_if.i_srat_wr_ready = ready;

  always_comb begin
    arat_bus = '0;
    for (int k = 0; k < ARF_NUM; k++) begin
      arat_bus[k*PRF_W +: PRF_W] = arat_m[k];
    end
  end

  dec_rat_recover_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_flush_req           (flush),
    .i_arat_flush_prf_code (arat_bus),
    .srat                  (srat_if.master),
    .o_rename_stall        (rename_stall),
    .o_retire_stall        (retire_stall),
    .o_recover_done        (recover_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks all outputs against a cycle that presents beat eb (eb < 0 means no
  // beat is presented), with the given done and stall levels.
  task automatic check_outputs(input string tag, input int eb, input bit ed, input bit es);
    logic [LANES-1:0]       e_wren;
    logic [LANES*ARF_W-1:0] e_arf;
    logic [LANES*PRF_W-1:0] e_prf;
    e_wren = '0;
    e_arf  = '0;
    e_prf  = '0;
    if (eb >= 0) begin
      for (int j = 0; j < LANES; j++) begin
        e_arf[j*ARF_W +: ARF_W] = ARF_W'(eb * LANES + j);
        e_prf[j*PRF_W +: PRF_W] = arat_m[eb * LANES + j];
        e_wren[j] = ready && !(eb == 0 && j == 0);
      end
    end
    chk({tag, ".wren"},   32'(srat_if.o_srat_wren),        32'(e_wren));
    chk({tag, ".arf"},    32'(srat_if.o_srat_wr_arf_code), 32'(e_arf));
    chk({tag, ".prf"},    32'(srat_if.o_srat_wr_prf_code), 32'(e_prf));
    chk({tag, ".done"},   32'(recover_done),               32'(ed));
    chk({tag, ".rstall"}, 32'(rename_stall),               32'(es));
    chk({tag, ".tstall"}, 32'(retire_stall),               32'(es));
    for (int j = 0; j < LANES; j++) begin
      if (srat_if.o_srat_wren[j]) wr_cnt++;
    end
  endtask

  task automatic step(input bit f, input bit r, input int eb, input bit ed, input bit es,
                      input string tag);
    @(posedge clk);
    #1;
    flush = f;
    ready = r;
    @(negedge clk);
    check_outputs(tag, eb, ed, es);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    wr_cnt = 0;
    flush  = 1'b0;
    ready  = 1'b0;
    for (int k = 0; k < ARF_NUM; k++) arat_m[k] = PRF_W'(k + 32);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_outputs("reset", -1, 1'b0, 1'b0);
    #19 rst_n = 1'b1;

    // 1: basic walk, ready held high.
    step(1'b1, 1'b1, -1, 1'b0, 1'b1, "t1.c0");
    for (int b = 0; b < BEATS; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t1.b%0d", b));
    step(1'b0, 1'b1, -1, 1'b1, 1'b1, "t1.done");
    step(1'b0, 1'b1, -1, 1'b0, 1'b0, "t1.idle");
    chk("t1.wrcnt", 32'(wr_cnt), 32'd31);

    // 2: ready low on cycles 3..5 holds beat 2.
    wr_cnt = 0;
    step(1'b1, 1'b1, -1, 1'b0, 1'b1, "t2.c0");
    step(1'b0, 1'b1, 0, 1'b0, 1'b1, "t2.c1");
    step(1'b0, 1'b1, 1, 1'b0, 1'b1, "t2.c2");
    for (int c = 3; c <= 5; c++) step(1'b0, 1'b0, 2, 1'b0, 1'b1, $sformatf("t2.c%0d", c));
    step(1'b0, 1'b1, 2, 1'b0, 1'b1, "t2.c6");
    for (int b = 3; b < BEATS; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t2.b%0d", b));
    step(1'b0, 1'b1, -1, 1'b1, 1'b1, "t2.done");
    step(1'b0, 1'b1, -1, 1'b0, 1'b0, "t2.idle");
    chk("t2.wrcnt", 32'(wr_cnt), 32'd31);

    // 3: second flush at cycle 4 restarts the walk.
    step(1'b1, 1'b1, -1, 1'b0, 1'b1, "t3.c0");
    for (int b = 0; b < 3; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t3.a%0d", b));
    step(1'b1, 1'b1, 3, 1'b0, 1'b1, "t3.c4");
    for (int b = 0; b < BEATS; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t3.b%0d", b));
    step(1'b0, 1'b1, -1, 1'b1, 1'b1, "t3.done");
    step(1'b0, 1'b1, -1, 1'b0, 1'b0, "t3.idle");

    // 4: flush on the DONE cycle suppresses done and restarts.
    step(1'b1, 1'b1, -1, 1'b0, 1'b1, "t4.c0");
    for (int b = 0; b < BEATS; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t4.a%0d", b));
    step(1'b1, 1'b1, -1, 1'b0, 1'b1, "t4.c9");
    for (int b = 0; b < BEATS; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t4.b%0d", b));
    step(1'b0, 1'b1, -1, 1'b1, 1'b1, "t4.done");
    step(1'b0, 1'b1, -1, 1'b0, 1'b0, "t4.idle");

    // 5: reset mid-walk, then a full walk.
    step(1'b1, 1'b1, -1, 1'b0, 1'b1, "t5.c0");
    for (int b = 0; b < 4; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t5.a%0d", b));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_outputs("t5.rst", -1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, -1, 1'b0, 1'b0, "t5.idle");
    wr_cnt = 0;
    step(1'b1, 1'b1, -1, 1'b0, 1'b1, "t5.c0b");
    for (int b = 0; b < BEATS; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t5.b%0d", b));
    step(1'b0, 1'b1, -1, 1'b1, 1'b1, "t5.done");
    chk("t5.wrcnt", 32'(wr_cnt), 32'd31);

    // 6: entry 0 is 0, all others 63; x0 never written.
    for (int k = 0; k < ARF_NUM; k++) arat_m[k] = (k == 0) ? '0 : PRF_W'(63);
    wr_cnt = 0;
    step(1'b1, 1'b1, -1, 1'b0, 1'b1, "t6.c0");
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("t6.b0.wren", 32'(srat_if.o_srat_wren), 32'h0000_000e);
    chk("t6.b0.prf", 32'(srat_if.o_srat_wr_prf_code), 32'h00ff_ffc0);
    check_outputs("t6.b0", 0, 1'b0, 1'b1);
    for (int b = 1; b < BEATS; b++) step(1'b0, 1'b1, b, 1'b0, 1'b1, $sformatf("t6.b%0d", b));
    step(1'b0, 1'b1, -1, 1'b1, 1'b1, "t6.done");
    step(1'b0, 1'b1, -1, 1'b0, 1'b0, "t6.idle");
    chk("t6.wrcnt", 32'(wr_cnt), 32'd31);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
